// File: rtl/cpu_regfile.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one clocked write port, $0 hard-wired to zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to a matching read port.
module cpu_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              wr_en;

    // Index 0 is excluded here so its storage stays at the reset value forever.
    assign wr_en = ena && we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr] <= wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (addr != '0) begin
            val = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (!rst && wr_en && (waddr == addr)) begin
                val = wdata;
            end
`endif
        end
        return val;
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

endmodule

// File: tb/tb_cpu_regfile.sv
// Directed checks of cpu_regfile plus a short seeded stream against a reference array.
// Expected same-cycle read-during-write values follow REGFILE_BYPASS_EN when defined.
module tb_cpu_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ena = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] raddr1 = '0;
    logic [AW-1:0] raddr2 = '0;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [DW-1:0] model [32];

    always #5 clk = ~clk;

    cpu_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic r, input logic e, input logic w, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(negedge clk);
        rst = r; ena = e; we = w; waddr = wa; wdata = wd; raddr1 = r1; raddr2 = r2;
        #1;
    endtask

    // One rising edge; the reference array follows the same edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (ena && we && waddr != '0) begin
            model[waddr] = wdata;
        end
        #1;
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (!rst && ena && we && waddr == a) return wdata;
`endif
        return model[a];
    endfunction

    initial begin
        logic [DW-1:0] pre7;

        // Reset, then every index on both ports must read zero
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, AW'(i), AW'(31 - i));
            check_val($sformatf("reset_r1[%0d]", i), rdata1, 32'h0);
            check_val($sformatf("reset_r2[%0d]", 31 - i), rdata2, 32'h0);
        end

        // Basic write, both ports on the same index
        drive(1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        check_val("wr5_r1", rdata1, 32'hDEADBEEF);
        check_val("wr5_r2", rdata2, 32'hDEADBEEF);

        // Write to $0 is dropped, even for a same-cycle read
        drive(1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5);
        check_val("wr0_same_cycle", rdata1, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
        check_val("wr0_r1", rdata1, 32'h0);
        check_val("wr0_reg5_kept", rdata2, 32'hDEADBEEF);

        // Read during write of the same index
        drive(1'b0, 1'b1, 1'b1, 5'd7, 32'h11, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 5'd7, 32'h22, 5'd7, 5'd5);
`ifdef REGFILE_BYPASS_EN
        pre7 = 32'h22;
`else
        pre7 = 32'h11;
`endif
        check_val("rdw7_pre_edge", rdata1, pre7);
        check_val("rdw7_other_port", rdata2, 32'hDEADBEEF);
        tick();
        check_val("rdw7_post_edge", rdata1, 32'h22);

        // ena=0 freezes state; reads still work
        drive(1'b0, 1'b1, 1'b1, 5'd9, 32'hA5, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 5'd9, 32'h5A, 5'd9, 5'd9);
        check_val("ena0_pre_edge", rdata1, 32'hA5);
        tick();
        check_val("ena0_post_edge", rdata2, 32'hA5);

        // rst in the same cycle as a write: write lost, everything cleared
        drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h5A, 5'd9, 5'd5);
        tick();
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd5);
        check_val("rst_wr9_lost", rdata1, 32'h0);
        check_val("rst_reg5_cleared", rdata2, 32'h0);

        // Seeded stream against the reference array
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, 31)), DW'($urandom), AW'($urandom_range(0, 31)),
                  AW'($urandom_range(0, 31)));
            check_val($sformatf("rand_r1[%0d]", c), rdata1, exp_rd(raddr1));
            check_val($sformatf("rand_r2[%0d]", c), rdata2, exp_rd(raddr2));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
